// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream block packer.
package axis_pkg;

  // Output-side sequencing: IDLE presents nothing, SEND holds a beat until it is taken.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Widest byte-enable the popcount helper accepts (512-bit data).
  localparam int MAX_KEEP_W = 64;

  // Number of enabled bytes in a keep mask; narrower masks are zero-extended by the caller.
  function automatic logic [7:0] popcount(input logic [MAX_KEEP_W-1:0] keep);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      n = n + {7'd0, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_fwft_fifo.sv
// First-word-fall-through FIFO: the oldest entry is always visible on rdata_o.
module axis_fwft_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 19
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);

  // Guard both ports so a misbehaving caller can never corrupt the pointers.
  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  // Occupancy is unchanged when a push and a pop coincide.
  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wr_en && rd_en) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Storage array carries no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/axis_block_packer.sv
// Re-frames an AXI-Stream into blocks of a runtime byte count, also closing
// a block at every source packet end. Output is gated by rd_en.
module axis_block_packer
  import axis_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8,
  parameter int DEPTH  = 16,
  parameter int BLK_W  = 12
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  input  logic [KEEP_W-1:0]      s_keep,
  output logic                   s_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  output logic                   m_last,
  output logic [KEEP_W-1:0]      m_keep,
  input  logic                   m_ready,
  input  logic                   rd_en,
  input  logic [BLK_W-1:0]       block_size,
  output logic                   last,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // One FIFO entry: the beat payload plus its source packet-end flag.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } entry_t;

  entry_t           wr_entry;
  entry_t           head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level_d;

  state_e           state_q;
  logic             m_valid_q;
  logic             last_q;
  logic             s_ready_q;
  logic [BLK_W-1:0] byte_cnt_q;
  logic [BLK_W-1:0] blk_q;

  logic [BLK_W-1:0] eff_size;
  logic [BLK_W:0]   cnt_sum;
  logic             size_hit;
  logic             m_last_w;

  assign wr_entry = '{data: s_data, keep: s_keep, last: s_last};
  assign push     = s_valid && s_ready_q && !full;
  assign pop      = m_valid_q && m_ready;

  axis_fwft_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Next occupancy, used to register s_ready and to decide whether SEND continues.
  always_comb begin
    level_d = level;
    if (push && !pop) begin
      level_d = level + LVL_W'(1);
    end else if (!push && pop) begin
      level_d = level - LVL_W'(1);
    end
  end

  // Block end test: a fresh block sees the live block_size, a running one its latched size.
  // One extra bit keeps the byte sum from wrapping; a beat is never split.
  always_comb begin
    eff_size = (byte_cnt_q == '0) ? block_size : blk_q;
    cnt_sum  = {1'b0, byte_cnt_q} + (BLK_W+1)'(popcount(MAX_KEEP_W'(head.keep)));
    size_hit = (eff_size != '0) && (cnt_sum >= {1'b0, eff_size});
    m_last_w = head.last || size_hit;
  end

  // Output sequencer with byte counter, per-block size latch and registered handshake flags.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      last_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      byte_cnt_q <= '0;
      blk_q      <= '0;
    end else begin
      s_ready_q <= (level_d != FULL_LVL);
      last_q    <= pop && m_last_w;
      case (state_q)
        IDLE: begin
          if (rd_en && !empty) begin
            state_q   <= SEND;
            m_valid_q <= 1'b1;
          end
        end
        SEND: begin
          // m_valid stays up until the beat is taken, even if rd_en drops meanwhile.
          if (pop) begin
            if (byte_cnt_q == '0) blk_q <= block_size;
            byte_cnt_q <= m_last_w ? '0 : cnt_sum[BLK_W-1:0];
            if (!(rd_en && (level_d != '0))) begin
              state_q   <= IDLE;
              m_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = head.data;
  assign m_keep  = head.keep;
  assign m_last  = m_last_w;
  assign last    = last_q;

endmodule
